// File: rtl/alu_pkg.sv
// Shared ALU sweep definitions: default widths, ALU opcode encodings and the
// sweep controller state enum.
package alu_pkg;
    localparam int DATA_W = 4;
    localparam int OP_W   = 2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {IDLE, SWEEP, OUT} state_t;
endpackage

// File: rtl/alu_sweep_ctrl.sv
// Runs both operands through every opcode of an external ALU, buffers the results,
// then streams them out. Define ALU_SWEEP_MASK_EN to add an op_mask result filter.
module alu_sweep_ctrl #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef ALU_SWEEP_MASK_EN
    input  logic [2**OP_W-1:0] op_mask,
`endif
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] alu_inA,
    output logic [DATA_W-1:0] alu_inB,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_ans,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [OP_W-1:0]   res_op,
    output logic              busy,
    output logic              done
);
    import alu_pkg::*;

    localparam int NUM = 2**OP_W;

    state_t            state;
    logic [DATA_W-1:0] opA, opB;
    logic [OP_W-1:0]   opCnt, rdPtr;
    logic [DATA_W-1:0] bufMem [NUM];
    logic [NUM-1:0]    maskQ;
    logic              doneQ;
    logic [OP_W:0]     firstHit, nextHit;

    // {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [OP_W:0] seekSet(input logic [NUM-1:0] m, input int from);
        logic [OP_W:0] r;
        r = '0;
        for (int i = NUM - 1; i >= 0; i--)
            if (i >= from && m[i]) r = {1'b1, OP_W'(i)};
        return r;
    endfunction

    assign firstHit = seekSet(maskQ, 0);
    assign nextHit  = seekSet(maskQ, int'(rdPtr) + 1);

`ifndef ALU_SWEEP_MASK_EN
    assign maskQ = '1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            opCnt <= '0;
            rdPtr <= '0;
            opA   <= '0;
            opB   <= '0;
            doneQ <= 1'b0;
`ifdef ALU_SWEEP_MASK_EN
            maskQ <= '0;
`endif
        end else begin
            doneQ <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    opA   <= a;
                    opB   <= b;
                    opCnt <= '0;
`ifdef ALU_SWEEP_MASK_EN
                    maskQ <= op_mask;
`endif
                    state <= SWEEP;
                end
                SWEEP: begin
                    opCnt <= opCnt + 1'b1;
                    if (opCnt == OP_W'(NUM - 1)) begin
                        // An empty mask has nothing to drain, so finish straight away.
                        if (firstHit[OP_W]) begin
                            state <= OUT;
                            rdPtr <= firstHit[OP_W-1:0];
                        end else begin
                            state <= IDLE;
                            doneQ <= 1'b1;
                        end
                    end
                end
                OUT: if (res_ready) begin
                    if (nextHit[OP_W]) begin
                        rdPtr <= nextHit[OP_W-1:0];
                    end else begin
                        state <= IDLE;
                        rdPtr <= '0;
                        doneQ <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result buffer is only ever read in OUT after a full sweep, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == SWEEP) bufMem[opCnt] <= alu_ans;
    end

    assign alu_inA   = (state == SWEEP) ? opA   : '0;
    assign alu_inB   = (state == SWEEP) ? opB   : '0;
    assign alu_op    = (state == SWEEP) ? opCnt : '0;
    assign res_valid = (state == OUT);
    assign res_data  = (state == OUT) ? bufMem[rdPtr] : '0;
    assign res_op    = (state == OUT) ? rdPtr : '0;
    assign busy      = (state != IDLE);
    assign done      = doneQ;
endmodule

// File: doc/alu_sweep_ctrl.md
ALU_SWEEP_CTRL -- requirements
Module: alu_sweep_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 4, operand/result width.
REQ-002 SHALL have parameter OP_W, default 2, ALU opcode width; sweep length is 2**OP_W (4).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a sweep; sampled only in IDLE.
REQ-006 SHALL have ports a, b  input  DATA_W each  operands, latched when start is accepted.
REQ-007 SHALL have ports alu_inA, alu_inB  output  DATA_W each  operands driven to the external combinational ALU.
REQ-008 SHALL have port alu_op  output  OP_W  opcode driven to the ALU.
REQ-009 SHALL have port alu_ans  input  DATA_W  ALU result, same-cycle combinational response to alu_inA/alu_inB/alu_op.
REQ-010 SHALL have ports res_valid  output  1; res_ready  input  1; res_data  output  DATA_W; res_op  output  OP_W  result stream.
REQ-011 SHALL have ports busy  output  1  high in any state but IDLE; done  output  1  one-cycle pulse after the last result transfer.

Function
REQ-012 SHALL implement FSM states IDLE, SWEEP, OUT.
REQ-013 IDLE: start=1 SHALL latch a, b, clear op_cnt to 0 and enter SWEEP next cycle; start=0 SHALL stay in IDLE.
REQ-014 SWEEP: alu_inA/alu_inB SHALL equal the latched operands and alu_op SHALL equal op_cnt; each edge SHALL write alu_ans into buf[op_cnt] and increment op_cnt.
REQ-015 SWEEP SHALL last exactly 4 cycles (op 0,1,2,3); after op_cnt=3 is captured, enter OUT with rd_ptr=0.
REQ-016 Outside SWEEP, alu_inA, alu_inB and alu_op SHALL be 0.
REQ-017 OUT: res_valid SHALL be 1, res_data=buf[rd_ptr], res_op=rd_ptr; outside OUT res_valid, res_data, res_op SHALL be 0.
REQ-018 Transfer SHALL occur on an edge with res_valid=1 and res_ready=1; rd_ptr then advances; res_data/res_op SHALL stay stable while res_ready=0.
REQ-019 Transfer of the last entry SHALL return to IDLE and assert done for exactly the next cycle.
REQ-020 start SHALL be ignored in SWEEP and OUT; start on the done cycle SHALL be accepted (IDLE).
REQ-021 Latency start-accept to first res_valid SHALL be 5 cycles with no stall.
REQ-022 op_cnt and rd_ptr SHALL be OP_W bits; no wrap beyond 3 occurs.

Reset
REQ-023 reset=1 SHALL force IDLE, op_cnt=0, rd_ptr=0, all outputs 0, from any state, aborting any sweep or drain.
REQ-024 Buffer contents SHALL need no reset; stale data never appears with res_valid=1.

Configuration
REQ-025 Macro ALU_SWEEP_MASK_EN defined: input op_mask[2**OP_W-1:0] SHALL exist, be latched at start, and OUT SHALL present only entries with mask bit 1, ascending op order, skipping others with no extra cycles.
REQ-026 With ALU_SWEEP_MASK_EN, latched mask 0 SHALL go SWEEP->IDLE directly with done pulsed; without the macro, no op_mask port exists and all 4 entries are output.

Structure
REQ-027 Shared package alu_pkg SHALL hold DATA_W, OP_W, ALU opcode constants (OP_ADD=00, OP_SUB=01, OP_AND=10, OP_OR=11) and the state enum.
REQ-028 No sub-module; the ALU stays external and the bench instantiates the team ALU against alu_* ports.

Verification
REQ-029 Reset, then start with a=1,b=1, res_ready=1 -> res stream (op,data) = (0,2),(1,0),(2,1),(3,1), then done pulse.
REQ-030 a=4'hF,b=1 -> add wraps: (0,0),(1,E),(2,1),(3,F).
REQ-031 res_ready held 0 three cycles during OUT -> res_data/res_op frozen, no loss or duplication.
REQ-032 reset asserted during SWEEP cycle 2 -> next cycle busy=0, all outputs 0; new start runs full sweep correctly.
REQ-033 start pulsed during SWEEP and OUT -> ignored; operands unchanged in results.
REQ-034 ALU_SWEEP_MASK_EN, op_mask=4'b1010, a=3,b=1 -> only (1,2),(3,3) output; op_mask=0 -> done with no res_valid.
